// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and requester indices for the memory port arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/memory bundle seen by the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0;
  logic [WIDTH-1:0] addr0;
  logic             req1;
  logic [WIDTH-1:0] addr1;
  logic             we1;
  logic [WIDTH-1:0] wdata1;
  logic             mem_ready;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;

  // Requesters and memory together drive the bundle; the arbiter answers it.
  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, mem_ready,
    input  gnt0, gnt1, done0, done1, mem_valid, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, mem_ready,
    output gnt0, gnt1, done0, done1, mem_valid, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// rtl/mem_port_arbiter_mux2.sv - two-input word multiplexer used to steer the memory address
module Mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t state;
  arb_state_t state_next;
  logic       last;
  logic       last_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= REQ_DATA;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // On completion the owner's own req is ignored, so a held req cannot be served twice in a row.
  always_comb begin
    state_next = state;
    last_next  = last;
    unique case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_next = (last == REQ_FETCH) ? BUSY1 : BUSY0;
        end else if (bus.req0) begin
          state_next = BUSY0;
        end else if (bus.req1) begin
          state_next = BUSY1;
        end
      end
      BUSY0: begin
        if (bus.mem_ready) begin
          last_next  = REQ_FETCH;
          state_next = bus.req1 ? BUSY1 : IDLE;
        end
      end
      BUSY1: begin
        if (bus.mem_ready) begin
          last_next  = REQ_DATA;
          state_next = bus.req0 ? BUSY0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt0      = (state == BUSY0);
  assign bus.gnt1      = (state == BUSY1);
  assign bus.mem_valid = bus.gnt0 | bus.gnt1;
  assign bus.done0     = bus.gnt0 & bus.mem_ready;
  assign bus.done1     = bus.gnt1 & bus.mem_ready;
  assign bus.mem_we    = bus.gnt1 & bus.we1;
  assign bus.mem_wdata = bus.wdata1;

  Mux2 #(
    .WIDTH(WIDTH)
  ) u_addr_mux (
    .d0(bus.addr0),
    .d1(bus.addr1),
    .s (bus.gnt1),
    .y (bus.mem_addr)
  );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port between instruction fetch (requester 0) and data load/store (requester 1). It owns the `req`/`gnt` handshake, holds each grant until the memory signals completion, and alternates fairly under contention. It also drives the select of the `Mux2` instance that steers the address onto the memory port. It sits between the processor's fetch/memory stages and the unified memory.

## Interface
Parameters:
- `WIDTH`, 32, address and write-data width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `req0`  in  1  fetch request; held until `done0`
- `addr0`  in  WIDTH  fetch address; stable while `req0`
- `req1`  in  1  data request; held until `done1`
- `addr1`  in  WIDTH  data address; stable while `req1`
- `we1`  in  1  data write enable; stable while `req1`
- `wdata1`  in  WIDTH  data write value; stable while `req1`
- `mem_ready`  in  1  memory completes the current access this cycle
- `gnt0`, `gnt1`  out  1  grant; at most one high
- `done0`, `done1`  out  1  completion pulse to each requester
- `mem_valid`  out  1  access in progress
- `mem_addr`  out  WIDTH  muxed address
- `mem_we`  out  1  write strobe
- `mem_wdata`  out  WIDTH  write data

## Operation
- States:
  - IDLE: no grant.
  - BUSY0: requester 0 owns the port.
  - BUSY1: requester 1 owns the port.
- `last` register records the last-served requester and resets to 1, so requester 0 wins the first tie.
- Transitions from IDLE:
  - Only `req0` high: go to BUSY0.
  - Only `req1` high: go to BUSY1.
  - Both high: grant the requester != `last`.
  - Neither high: stay in IDLE.
- In BUSY_k:
  - `mem_ready` low: stay.
  - `mem_ready` high: set `last` = k and complete the access. Next state is BUSY of the other requester if its `req` is high, else IDLE.
  - `req_k` is ignored for the next-state decision in the completion cycle, so no double service.
- Outputs, all decoded from state:
  - `gnt_k` = (state == BUSY_k).
  - `mem_valid` = `gnt0 | gnt1`.
  - `done_k` = `gnt_k & mem_ready` (combinational).
  - `mem_addr` = `gnt1 ? addr1 : addr0`.
  - `mem_we` = `gnt1 & we1`.
  - `mem_wdata` = `wdata1`.
- Requesters drop `req` in the cycle after `done`. A `req` that is still high in IDLE after its own `done` is treated as a new request.
- `req` deasserted mid-grant is a protocol violation. The grant is held regardless until `mem_ready`.

## Timing
- Reset values:
  - state = IDLE, `last` = 1.
  - `gnt0`/`gnt1`/`done0`/`done1`/`mem_valid`/`mem_we` = 0.
  - `mem_addr` = `addr0`.
- Latency: `req` sampled high at edge N in IDLE gives `gnt` high during cycle N+1. With zero-wait memory, `done` also occurs in cycle N+1.
- Back-to-back under contention: the other requester's grant starts the cycle after `done`, with no IDLE bubble.
- Wait states: the grant and muxed outputs stay constant for every cycle `mem_ready` is low.
- Reset mid-transaction: the next edge forces IDLE. `mem_valid` and `gnt` drop in that cycle, and no `done` is issued for the aborted access.
- `mem_ready` while IDLE is ignored, with no `done`.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY0, BUSY1}.
  - Requester index constants `REQ_FETCH` = 0 and `REQ_DATA` = 1.
- Sub-module: one `Mux2 #(WIDTH)` for `mem_addr`, with `d0` = `addr0`, `d1` = `addr1`, `s` = `gnt1`.
- State register and `last` register live in a single always_ff block. Next-state and output decode are combinational.

## Test plan
- Reset: hold `reset` high for 3 cycles with `req0` = `req1` = 1 → all grants, dones and `mem_valid` = 0. After release, the first grant is `gnt0`.
- Single fetch, zero-wait: `req0` = 1, `addr0` = 0x100, `mem_ready` = 1 → next cycle `gnt0` = 1, `mem_addr` = 0x100, `done0` = 1, `mem_we` = 0.
- Contention round-robin: both requests held, `mem_ready` = 1 permanently → grants alternate 0,1,0,1 with no IDLE cycles. `mem_addr` alternates between `addr0` and `addr1`.
- Wait states with store: `req1` = 1, `addr1` = 0x2000, `we1` = 1, `wdata1` = 0xDEADBEEF; `mem_ready` low for 3 cycles then high → `gnt1`, `mem_we` and outputs held for 4 cycles. `done1` fires only on the 4th.
- Reset mid-transaction: assert `reset` during BUSY1 with `mem_ready` = 0 → next cycle IDLE, `gnt1` = 0, no `done1`. After reset, a pending `req1` with `req0` low is re-granted.
- Spurious `mem_ready` in IDLE: no requests, `mem_ready` = 1 for 5 cycles → no `done`, `mem_valid` stays 0.
